// File: rtl/pilot_frame_sequencer.sv
// ---------------------------------------------------------------------------
// pilot_frame_sequencer
//
// Slot scheduler for a framed symbol stream. Every frame opens with a
// pilot block of cfg_pilot_len symbols and then carries cfg_frame_len data
// symbols. When cfg_pilot_period is non-zero, an extra pilot block is
// inserted after every cfg_pilot_period data symbols. Configuration is
// captured at each frame start and held for the whole frame.
//
// Ports
//   clk                  in   clock, rising edge
//   rst                  in   asynchronous active-low reset
//   enable               in   permits new frames to start
//   ready                in   beat qualifier, one symbol per ready cycle
//   event_frame_started  in   resync request, aborts the current frame
//   cfg_frame_len        in   data symbols per frame
//   cfg_pilot_len        in   pilot symbols per pilot block
//   cfg_pilot_period     in   data symbols between mid-frame pilots (0 = off)
//   pilot_sel            out  current slot is a pilot slot
//   start_frame          out  pulse after the first pilot beat of a frame
//   end_frame            out  pulse after the last data beat of a frame
//   frame_count          out  completed frames, wraps
//   cfg_err              out  sticky illegal-configuration flag
// ---------------------------------------------------------------------------
module pilot_frame_sequencer #(
  parameter int unsigned LEN_W  = 13,
  parameter int unsigned PIL_W  = 8,
  parameter int unsigned FCNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              ready,
  input  logic              event_frame_started,
  input  logic [LEN_W-1:0]  cfg_frame_len,
  input  logic [PIL_W-1:0]  cfg_pilot_len,
  input  logic [LEN_W-1:0]  cfg_pilot_period,
  output logic              pilot_sel,
  output logic              start_frame,
  output logic              end_frame,
  output logic [FCNT_W-1:0] frame_count,
  output logic              cfg_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PILOT = 2'd1,
    S_DATA  = 2'd2
  } state_e;

  // State and latched configuration
  state_e             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [PIL_W-1:0]   pil_len_q, pil_len_d;
  logic [LEN_W-1:0]   per_q, per_d;

  // Position counters
  logic [PIL_W-1:0]   pil_cnt_q, pil_cnt_d;
  logic [LEN_W-1:0]   data_cnt_q, data_cnt_d;
  logic [LEN_W-1:0]   per_cnt_q, per_cnt_d;

  // Registered outputs
  logic               pilot_sel_q, pilot_sel_d;
  logic               start_q, start_d;
  logic               end_q, end_d;
  logic [FCNT_W-1:0]  fcnt_q, fcnt_d;
  logic               err_q, err_d;

  // Decode helpers
  logic               cfg_ok_c;
  logic               pil_last_c;
  logic               data_last_c;
  logic               per_hit_c;
  logic               launch_c;
  logic               relatch_c;

  // Legality of the configuration currently presented on the inputs
  assign cfg_ok_c = (cfg_frame_len != '0) && (cfg_pilot_len != '0);

  // Last-beat detectors on the latched configuration, full width
  assign pil_last_c  = (pil_cnt_q == (pil_len_q - PIL_W'(1)));
  assign data_last_c = (data_cnt_q == (len_q - LEN_W'(1)));
  assign per_hit_c   = (per_q != '0) && (per_cnt_q == (per_q - LEN_W'(1)));

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    pil_len_d   = pil_len_q;
    per_d       = per_q;
    pil_cnt_d   = pil_cnt_q;
    data_cnt_d  = data_cnt_q;
    per_cnt_d   = per_cnt_q;
    start_d     = 1'b0;
    end_d       = 1'b0;
    fcnt_d      = fcnt_q;
    err_d       = err_q;
    launch_c    = 1'b0;
    relatch_c   = 1'b0;

    if (event_frame_started) begin
      // Resync: drop the frame silently, restart or park
      relatch_c  = 1'b1;
      pil_cnt_d  = '0;
      data_cnt_d = '0;
      per_cnt_d  = '0;
      if (enable) begin
        launch_c = 1'b1;
      end else begin
        state_d = S_IDLE;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (enable) begin
            launch_c = 1'b1;
          end
        end

        S_PILOT: begin
          if (ready) begin
            // Leading block is the only pilot block seen with data_cnt == 0
            if ((pil_cnt_q == '0) && (data_cnt_q == '0)) begin
              start_d = 1'b1;
            end
            if (pil_last_c) begin
              state_d   = S_DATA;
              pil_cnt_d = '0;
            end else begin
              pil_cnt_d = pil_cnt_q + PIL_W'(1);
            end
          end
        end

        S_DATA: begin
          if (ready) begin
            data_cnt_d = data_cnt_q + LEN_W'(1);
            per_cnt_d  = per_cnt_q + LEN_W'(1);
            if (data_last_c) begin
              // End of frame wins over a coincident mid-frame pilot
              end_d      = 1'b1;
              fcnt_d     = fcnt_q + FCNT_W'(1);
              pil_cnt_d  = '0;
              data_cnt_d = '0;
              per_cnt_d  = '0;
              if (enable) begin
                launch_c = 1'b1;
              end else begin
                state_d = S_IDLE;
              end
            end else if (per_hit_c) begin
              state_d   = S_PILOT;
              per_cnt_d = '0;
            end
          end
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    // Frame start: capture config, clear counters, reject illegal config
    if (launch_c) begin
      relatch_c  = 1'b1;
      pil_cnt_d  = '0;
      data_cnt_d = '0;
      per_cnt_d  = '0;
      if (cfg_ok_c) begin
        state_d = S_PILOT;
      end else begin
        state_d = S_IDLE;
        err_d   = 1'b1;
      end
    end

    if (relatch_c) begin
      len_d     = cfg_frame_len;
      pil_len_d = cfg_pilot_len;
      per_d     = cfg_pilot_period;
    end

    pilot_sel_d = (state_d == S_PILOT);
  end

  // State, configuration and counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      pil_len_q  <= '0;
      per_q      <= '0;
      pil_cnt_q  <= '0;
      data_cnt_q <= '0;
      per_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      pil_len_q  <= pil_len_d;
      per_q      <= per_d;
      pil_cnt_q  <= pil_cnt_d;
      data_cnt_q <= data_cnt_d;
      per_cnt_q  <= per_cnt_d;
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pilot_sel_q <= 1'b0;
      start_q     <= 1'b0;
      end_q       <= 1'b0;
      fcnt_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      pilot_sel_q <= pilot_sel_d;
      start_q     <= start_d;
      end_q       <= end_d;
      fcnt_q      <= fcnt_d;
      err_q       <= err_d;
    end
  end

  assign pilot_sel   = pilot_sel_q;
  assign start_frame = start_q;
  assign end_frame   = end_q;
  assign frame_count = fcnt_q;
  assign cfg_err     = err_q;

endmodule

// File: tb/tb_pilot_frame_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pilot_frame_sequencer
//
// Table of per-cycle {inputs, expected outputs} records applied in order from
// reset release, followed by hand-written sequences for async reset, illegal
// pilot length, frame_count wrap (FCNT_W=2 instance) and maximum pilot length.
// ---------------------------------------------------------------------------
module tb_pilot_frame_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        ready;
  logic        evt;
  logic [12:0] cfg_len;
  logic [7:0]  cfg_pil;
  logic [12:0] cfg_per;

  logic        pilot_sel, start_frame, end_frame, cfg_err;
  logic [15:0] frame_count;
  logic        pilot_sel2, start_frame2, end_frame2, cfg_err2;
  logic [1:0]  frame_count2;

  always #5 clk = ~clk;

  pilot_frame_sequencer dut (
    .clk                 (clk),
    .rst                 (rst),
    .enable              (enable),
    .ready               (ready),
    .event_frame_started (evt),
    .cfg_frame_len       (cfg_len),
    .cfg_pilot_len       (cfg_pil),
    .cfg_pilot_period    (cfg_per),
    .pilot_sel           (pilot_sel),
    .start_frame         (start_frame),
    .end_frame           (end_frame),
    .frame_count         (frame_count),
    .cfg_err             (cfg_err)
  );

  pilot_frame_sequencer #(.FCNT_W(2)) dut2 (
    .clk                 (clk),
    .rst                 (rst),
    .enable              (enable),
    .ready               (ready),
    .event_frame_started (evt),
    .cfg_frame_len       (cfg_len),
    .cfg_pilot_len       (cfg_pil),
    .cfg_pilot_period    (cfg_per),
    .pilot_sel           (pilot_sel2),
    .start_frame         (start_frame2),
    .end_frame           (end_frame2),
    .frame_count         (frame_count2),
    .cfg_err             (cfg_err2)
  );

  typedef struct {
    string       tag;
    logic        en, rdy, ev;
    logic [12:0] len;
    logic [7:0]  pil;
    logic [12:0] per;
    logic        ps, sf, ef;
    logic [15:0] fc;
    logic        err;
  } vec_t;

  vec_t        vq[$];
  logic [12:0] cur_len;
  logic [7:0]  cur_pil;
  logic [12:0] cur_per;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic add(input string tag, input logic en, input logic rdy,
                     input logic ev, input logic ps, input logic sf,
                     input logic ef, input int fc, input logic err);
    vec_t v;
    v.tag = tag; v.en = en; v.rdy = rdy; v.ev = ev;
    v.len = cur_len; v.pil = cur_pil; v.per = cur_per;
    v.ps = ps; v.sf = sf; v.ef = ef; v.fc = 16'(fc); v.err = err;
    vq.push_back(v);
  endtask

  task automatic chk(input string tag, input int idx, input logic ps,
                     input logic sf, input logic ef, input logic [15:0] fc,
                     input logic err);
    n_vec++;
    if (pilot_sel !== ps || start_frame !== sf || end_frame !== ef ||
        frame_count !== fc || cfg_err !== err || frame_count2 !== fc[1:0]) begin
      n_err++;
      $display("FAIL %s[%0d]: got ps=%b sf=%b ef=%b fc=%0d fc2=%0d err=%b, want ps=%b sf=%b ef=%b fc=%0d fc2=%0d err=%b",
               tag, idx, pilot_sel, start_frame, end_frame, frame_count, frame_count2,
               cfg_err, ps, sf, ef, fc, fc[1:0], err);
    end
  endtask

  task automatic chk_int(input string tag, input int got, input int want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, got, want);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp2 [5];
    int got;
    int n_p;
    int n_d;

    // ---------------- vector table ----------------
    // Back-to-back frames: len=4 pilot=2 period=0
    cur_len = 13'd4; cur_pil = 8'd2; cur_per = 13'd0;
    add("basic", 1,1,0, 1,0,0, 0, 0);
    add("basic", 1,1,0, 1,1,0, 0, 0);
    add("basic", 1,1,0, 0,0,0, 0, 0);
    add("basic", 1,1,0, 0,0,0, 0, 0);
    add("basic", 1,1,0, 0,0,0, 0, 0);
    add("basic", 1,1,0, 0,0,0, 0, 0);
    add("basic", 1,1,0, 1,0,1, 1, 0);
    add("basic", 1,1,0, 1,1,0, 1, 0);
    add("basic", 1,1,0, 0,0,0, 1, 0);
    add("basic", 1,1,0, 0,0,0, 1, 0);
    add("basic", 1,1,0, 0,0,0, 1, 0);
    add("basic", 1,1,0, 0,0,0, 1, 0);
    add("basic", 1,1,0, 1,0,1, 2, 0);
    // Same frame with ready alternating 0,1
    add("stretch", 1,0,0, 1,0,0, 2, 0);
    add("stretch", 1,1,0, 1,1,0, 2, 0);
    add("stretch", 1,0,0, 1,0,0, 2, 0);
    add("stretch", 1,1,0, 0,0,0, 2, 0);
    add("stretch", 1,0,0, 0,0,0, 2, 0);
    add("stretch", 1,1,0, 0,0,0, 2, 0);
    add("stretch", 1,0,0, 0,0,0, 2, 0);
    add("stretch", 1,1,0, 0,0,0, 2, 0);
    add("stretch", 1,0,0, 0,0,0, 2, 0);
    add("stretch", 1,1,0, 0,0,0, 2, 0);
    add("stretch", 1,0,0, 0,0,0, 2, 0);
    add("stretch", 1,1,0, 1,0,1, 3, 0);
    add("stretch", 1,0,0, 1,0,0, 3, 0);
    // Enable dropped mid-frame: frame completes, then idle
    add("en_off", 0,1,0, 1,1,0, 3, 0);
    add("en_off", 0,1,0, 0,0,0, 3, 0);
    add("en_off", 0,1,0, 0,0,0, 3, 0);
    add("en_off", 0,1,0, 0,0,0, 3, 0);
    add("en_off", 0,1,0, 0,0,0, 3, 0);
    add("en_off", 0,1,0, 0,0,1, 4, 0);
    add("en_off", 0,1,0, 0,0,0, 4, 0);
    // Mid-frame pilots: len=5 pilot=2 period=2
    cur_len = 13'd5; cur_pil = 8'd2; cur_per = 13'd2;
    add("midpil", 1,1,0, 1,0,0, 4, 0);
    add("midpil", 1,1,0, 1,1,0, 4, 0);
    add("midpil", 1,1,0, 0,0,0, 4, 0);
    add("midpil", 1,1,0, 0,0,0, 4, 0);
    add("midpil", 1,1,0, 1,0,0, 4, 0);
    add("midpil", 1,1,0, 1,0,0, 4, 0);
    add("midpil", 1,1,0, 0,0,0, 4, 0);
    add("midpil", 1,1,0, 0,0,0, 4, 0);
    add("midpil", 1,1,0, 1,0,0, 4, 0);
    add("midpil", 1,1,0, 1,0,0, 4, 0);
    add("midpil", 1,1,0, 0,0,0, 4, 0);
    add("midpil", 1,1,0, 1,0,1, 5, 0);
    // Resync relatches len=4 pilot=2 period=0, then resync on 3rd data beat
    cur_len = 13'd4; cur_pil = 8'd2; cur_per = 13'd0;
    add("resync", 1,1,1, 1,0,0, 5, 0);
    add("resync", 1,1,0, 1,1,0, 5, 0);
    add("resync", 1,1,0, 0,0,0, 5, 0);
    add("resync", 1,1,0, 0,0,0, 5, 0);
    add("resync", 1,1,0, 0,0,0, 5, 0);
    add("resync", 1,1,1, 1,0,0, 5, 0);
    add("resync", 1,1,0, 1,1,0, 5, 0);
    add("resync", 1,1,0, 0,0,0, 5, 0);
    add("resync", 1,1,0, 0,0,0, 5, 0);
    add("resync", 1,1,0, 0,0,0, 5, 0);
    add("resync", 1,1,0, 0,0,0, 5, 0);
    add("resync", 1,1,0, 1,0,1, 6, 0);
    add("resync", 0,1,1, 0,0,0, 6, 0);
    add("resync", 0,1,0, 0,0,0, 6, 0);
    // Illegal frame length sets a sticky error
    cur_len = 13'd0;
    add("cfgerr", 1,1,0, 0,0,0, 6, 1);
    add("cfgerr", 1,1,0, 0,0,0, 6, 1);
    cur_len = 13'd4;
    add("cfgerr", 1,1,0, 1,0,0, 6, 1);
    add("cfgerr", 1,1,0, 1,1,0, 6, 1);

    // ---------------- reset state ----------------
    rst = 1'b0; enable = 1'b0; ready = 1'b0; evt = 1'b0;
    cfg_len = 13'd4; cfg_pil = 8'd2; cfg_per = 13'd0;
    #12;
    chk("reset", 0, 0, 0, 0, 16'd0, 0);
    @(negedge clk);
    rst = 1'b1;

    // ---------------- apply table ----------------
    for (int i = 0; i < vq.size(); i++) begin
      enable  = vq[i].en;
      ready   = vq[i].rdy;
      evt     = vq[i].ev;
      cfg_len = vq[i].len;
      cfg_pil = vq[i].pil;
      cfg_per = vq[i].per;
      @(posedge clk);
      #1;
      chk(vq[i].tag, i, vq[i].ps, vq[i].sf, vq[i].ef, vq[i].fc, vq[i].err);
    end

    // ---------------- async reset mid-frame ----------------
    evt = 1'b0;
    rst = 1'b0;
    #1;
    chk("async_rst", 0, 0, 0, 0, 16'd0, 0);
    n_vec++;
    if (pilot_sel2 !== 1'b0 || start_frame2 !== 1'b0 || end_frame2 !== 1'b0 ||
        frame_count2 !== 2'd0 || cfg_err2 !== 1'b0) begin
      n_err++;
      $display("FAIL async_rst2: got ps=%b sf=%b ef=%b fc=%0d err=%b, want all 0",
               pilot_sel2, start_frame2, end_frame2, frame_count2, cfg_err2);
    end
    @(posedge clk);
    #1;
    chk("rst_hold", 0, 0, 0, 0, 16'd0, 0);
    enable = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_idle", 0, 0, 0, 0, 16'd0, 0);

    // ---------------- illegal pilot length ----------------
    cfg_len = 13'd4; cfg_pil = 8'd0; enable = 1'b1;
    @(posedge clk);
    #1;
    chk("pil0_err", 0, 0, 0, 0, 16'd0, 1);
    enable = 1'b0;
    rst = 1'b0;
    #1;
    chk("err_clear", 0, 0, 0, 0, 16'd0, 0);
    @(negedge clk);
    rst = 1'b1;

    // ---------------- frame_count wrap on FCNT_W=2 ----------------
    exp2[0] = 1; exp2[1] = 2; exp2[2] = 3; exp2[3] = 0; exp2[4] = 1;
    cfg_len = 13'd1; cfg_pil = 8'd1; cfg_per = 13'd0;
    enable = 1'b1; ready = 1'b1;
    got = 0;
    for (int c = 0; c < 40 && got < 5; c++) begin
      @(posedge clk);
      #1;
      if (end_frame === 1'b1) begin
        chk_int($sformatf("wrap_fc2_%0d", got), int'(frame_count2), exp2[got]);
        chk_int($sformatf("wrap_fc_%0d", got), int'(frame_count), got + 1);
        got++;
      end
    end
    chk_int("wrap_frames_seen", got, 5);

    // ---------------- maximum pilot length ----------------
    enable = 1'b0;
    rst = 1'b0;
    #1;
    @(negedge clk);
    rst = 1'b1;
    cfg_len = 13'd3; cfg_pil = 8'd255; cfg_per = 13'd0;
    enable = 1'b1; ready = 1'b1;
    n_p = 0;
    for (int c = 0; c < 600; c++) begin
      @(posedge clk);
      #1;
      if (pilot_sel === 1'b1) n_p++;
      else break;
    end
    chk_int("pil255_slots", n_p, 255);
    n_d = 1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (pilot_sel === 1'b0) n_d++;
      else break;
    end
    chk_int("pil255_data_slots", n_d, 3);
    chk_int("pil255_end_frame", int'(end_frame), 1);
    chk_int("pil255_fc", int'(frame_count), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pilot_frame_sequencer.md
PILOT_FRAME_SEQUENCER -- requirements
Module: pilot_frame_sequencer

Interface
REQ-001 Parameter LEN_W, default 13: width of frame-length, period and data counters.
REQ-002 Parameter PIL_W, default 8: width of pilot-length and pilot counters.
REQ-003 Parameter FCNT_W, default 16: width of the frame_count output.
REQ-004 clk  in  1: single clock; all state changes on its rising edge.
REQ-005 rst  in  1: asynchronous, active-low reset; deassertion is synchronous to clk.
REQ-006 enable  in  1: high permits new frames to start.
REQ-007 ready  in  1: beat qualifier; a cycle with ready=1 transfers one symbol.
REQ-008 event_frame_started  in  1: synchronous resync request; aborts the current frame.
REQ-009 cfg_frame_len  in  LEN_W: data symbols per frame.
REQ-010 cfg_pilot_len  in  PIL_W: pilot symbols per pilot block.
REQ-011 cfg_pilot_period  in  LEN_W: data symbols between mid-frame pilot blocks; 0 disables mid-frame pilots.
REQ-012 pilot_sel  out  1: current symbol slot is a pilot (1) or data (0).
REQ-013 start_frame  out  1: one-cycle pulse marking the start of a frame.
REQ-014 end_frame  out  1: one-cycle pulse marking the end of a frame.
REQ-015 frame_count  out  FCNT_W: number of completed frames.
REQ-016 cfg_err  out  1: sticky flag; latched configuration was illegal.

Function
REQ-017 States: IDLE, PILOT, DATA; pilot_sel=1 exactly in PILOT; state is registered.
REQ-018 Config latch: cfg_* sampled into internal registers on every frame start (IDLE->PILOT, end-of-frame->PILOT, resync); registers do not change mid-frame.
REQ-019 IDLE, enable=1, latched len>0 and pilot_len>0: next state PILOT, all counters 0.
REQ-020 IDLE, enable=1, cfg_frame_len=0 or cfg_pilot_len=0: cfg_err<=1, stay IDLE; cfg_err clears only on reset.
REQ-021 PILOT: each beat increments pil_cnt; beat with pil_cnt==pilot_len-1 -> DATA, pil_cnt<=0.
REQ-022 DATA: each beat increments data_cnt and per_cnt.
REQ-023 DATA, beat with data_cnt==frame_len-1: end of frame; end_frame=1 next cycle; frame_count+1; next state PILOT if enable else IDLE.
REQ-024 DATA, otherwise, period!=0 and beat with per_cnt==period-1: next state PILOT (mid-frame block), per_cnt<=0.
REQ-025 End of frame outranks a mid-frame pilot in the same beat; no mid-frame pilot precedes the next frame's leading pilot.
REQ-026 Every frame begins with a pilot block; start_frame=1 in the cycle after the beat transferring the frame's first pilot symbol.
REQ-027 ready=0: no counter or state change; pilot_sel holds.
REQ-028 event_frame_started=1 (priority over ready): counters cleared, config relatched, next state PILOT if enable else IDLE; no end_frame pulse; frame_count unchanged.
REQ-029 enable deassertion mid-frame: current frame completes normally, then IDLE.
REQ-030 frame_count wraps from 2^FCNT_W-1 to 0 without error.
REQ-031 Counter comparisons are at full parameter width; cfg values up to 2^LEN_W-1 / 2^PIL_W-1 are legal.

Reset
REQ-032 rst=0 forces, asynchronously: state IDLE, all counters 0, pilot_sel=0, start_frame=0, end_frame=0, frame_count=0, cfg_err=0.
REQ-033 Reset asserted mid-frame discards the frame with no end_frame pulse; after release, operation restarts from IDLE.

Verification
REQ-034 len=4, pilot=2, period=0, ready=1, enable=1 -> pilot_sel 1,1,0,0,0,0 repeating; one start_frame and one end_frame per 6 cycles; frame_count increments per frame.
REQ-035 len=5, pilot=2, period=2, ready=1 -> pilot_sel 1,1,0,0,1,1,0,0,1,1,0 then next frame; single end_frame after the 11th beat.
REQ-036 REQ-034 config with ready toggling 1,0 -> identical symbol sequence stretched 2x; no pulse lost or duplicated.
REQ-037 event_frame_started during the 3rd data beat -> next cycle in PILOT, pil_cnt=0; no end_frame; frame_count unchanged.
REQ-038 cfg_frame_len=0 with enable=1 -> cfg_err=1, state IDLE, pilot_sel=0; cfg_err remains 1 after a valid config until rst.
REQ-039 FCNT_W=2, run 5 frames -> frame_count 1,2,3,0,1; reset mid-frame -> all outputs 0 immediately.
